// File: rtl/fechadura_pkg.sv
// Shared lock types: keypad entry packet, key-code constants and FSM state enums
// for the digit collector and the lock control unit.
package fechadura_pkg;

   localparam int unsigned SENHA_DIGITS = 20;

   localparam logic [3:0] KEY_ENTER    = 4'hA;
   localparam logic [3:0] KEY_CANCEL   = 4'hB;
   localparam logic [3:0] CODE_EXPIRED = 4'hE;
   localparam logic [3:0] CODE_EMPTY   = 4'hF;

   // digits[0] is the newest digit and sits in the least-significant nibble
   typedef struct packed {
      logic [SENHA_DIGITS-1:0][3:0] digits;
   } senhaPac_t;

   localparam senhaPac_t PACOTE_VAZIO = senhaPac_t'({SENHA_DIGITS{CODE_EMPTY}});

   typedef enum logic [1:0] {
      IDLE,
      COLETANDO,
      EMITIR
   } coletor_estado_t;

   typedef enum logic [2:0] {
      FECH_TRANCADA,
      FECH_AGUARDA_SENHA,
      FECH_VERIFICA,
      FECH_ABERTA,
      FECH_BLOQUEADA
   } fechadura_estado_t;

   function automatic senhaPac_t pacote_codigo(input logic [3:0] codigo);
      senhaPac_t p;
      p = PACOTE_VAZIO;
      p.digits[0] = codigo;
      return p;
   endfunction

endpackage

// File: rtl/coletor_digitos_temporizador.sv
// Inactivity timer: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT_CYCLES-1.
module temporizador_inatividade #(
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [31:0] LIMITE = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + 32'd1;
   end

   assign expired = enable && (cnt == LIMITE);

endmodule

// File: rtl/coletor_digitos.sv
// Keypad digit collector: assembles digit keys into a packet, terminated by
// enter, cancel or inactivity timeout, and strobes the packet out for one cycle.
module coletor_digitos
   import fechadura_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 5000,
   parameter int unsigned MAX_DIGITS     = SENHA_DIGITS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       teclado_en,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output senhaPac_t  digitos_value,
   output logic       digitos_valid
);

   localparam logic [4:0] MAX_CNT = 5'(MAX_DIGITS);

   coletor_estado_t state, state_n;
   logic [4:0]      count, count_n;
   senhaPac_t       buffer, buffer_n, pacote_n;
   logic            emit_n;
   logic            tmr_clear, tmr_expired, key_accept;
   logic            is_digit, is_enter, is_cancel;

   assign is_digit  = key_valid && (key_code <= 4'd9);
   assign is_enter  = key_valid && (key_code == KEY_ENTER);
   assign is_cancel = key_valid && (key_code == KEY_CANCEL);

   // A full buffer swallows further digits without touching the timer.
   assign key_accept = (is_digit && (count < MAX_CNT)) || is_enter || is_cancel;
   assign tmr_clear  = !teclado_en || (state != COLETANDO) || key_accept;

   temporizador_inatividade #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_temporizador (
      .clk    (clk),
      .rst    (rst),
      .clear  (tmr_clear),
      .enable (state == COLETANDO),
      .expired(tmr_expired)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_n  = state;
      count_n  = count;
      buffer_n = buffer;
      pacote_n = digitos_value;
      emit_n   = 1'b0;

      if (!teclado_en) begin
         state_n  = IDLE;
         count_n  = '0;
         buffer_n = PACOTE_VAZIO;
      end else begin
         unique case (state)
            IDLE: begin
               if (is_digit) begin
                  buffer_n = pacote_codigo(key_code);
                  count_n  = 5'd1;
                  state_n  = COLETANDO;
               end else if (is_enter) begin
                  pacote_n = PACOTE_VAZIO;
                  emit_n   = 1'b1;
                  state_n  = EMITIR;
               end else if (is_cancel) begin
                  pacote_n = pacote_codigo(KEY_CANCEL);
                  buffer_n = PACOTE_VAZIO;
                  count_n  = '0;
                  emit_n   = 1'b1;
                  state_n  = EMITIR;
               end
            end
            COLETANDO: begin
               if (is_digit) begin
                  if (count < MAX_CNT) begin
                     buffer_n.digits = {buffer.digits[SENHA_DIGITS-2:0], key_code};
                     count_n         = count + 5'd1;
                  end
               end else if (is_enter) begin
                  pacote_n = buffer;
                  emit_n   = 1'b1;
                  state_n  = EMITIR;
               end else if (is_cancel) begin
                  pacote_n = pacote_codigo(KEY_CANCEL);
                  buffer_n = PACOTE_VAZIO;
                  count_n  = '0;
                  emit_n   = 1'b1;
                  state_n  = EMITIR;
               end else if (tmr_expired) begin
                  pacote_n = pacote_codigo(CODE_EXPIRED);
                  buffer_n = PACOTE_VAZIO;
                  count_n  = '0;
                  emit_n   = 1'b1;
                  state_n  = EMITIR;
               end
            end
            EMITIR: begin
               count_n = '0;
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         count         <= '0;
         buffer        <= PACOTE_VAZIO;
         digitos_value <= PACOTE_VAZIO;
         digitos_valid <= 1'b0;
      end else begin
         state         <= state_n;
         count         <= count_n;
         buffer        <= buffer_n;
         digitos_value <= pacote_n;
         digitos_valid <= emit_n;
      end
   end

endmodule

// File: tb/tb_coletor_digitos.sv
// Self-checking bench for coletor_digitos: table of key sequences with
// hand-computed packets, plus directed timeout, enable and reset sequences.
module tb_coletor_digitos;
   import fechadura_pkg::*;

   localparam int unsigned T = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       teclado_en;
   logic [3:0] key_code;
   logic       key_valid;
   senhaPac_t  digitos_value;
   logic       digitos_valid;

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   logic [79:0] pac_seen = '0;

   coletor_digitos #(.TIMEOUT_CYCLES(T)) dut (
      .clk          (clk),
      .rst          (rst),
      .teclado_en   (teclado_en),
      .key_code     (key_code),
      .key_valid    (key_valid),
      .digitos_value(digitos_value),
      .digitos_valid(digitos_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (digitos_valid) begin
         pulses   <= pulses + 1;
         pac_seen <= digitos_value;
      end
   end

   typedef struct {
      string            name;
      int               n;
      logic [23:0][3:0] keys;
      logic [79:0]      exp;
   } vec_t;

   function automatic vec_t mk(input string name, input string seq, input logic [79:0] exp);
      vec_t v;
      byte  c;
      v.name = name;
      v.n    = seq.len();
      v.keys = '0;
      v.exp  = exp;
      for (int i = 0; i < seq.len(); i++) begin
         c = seq[i];
         if (c >= "0" && c <= "9") v.keys[i] = 4'(c - "0");
         else                      v.keys[i] = 4'(c - "A" + 10);
      end
      return v;
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   localparam logic [79:0] VAZIO  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
   localparam logic [79:0] EXPIRA = 80'hFFFF_FFFF_FFFF_FFFF_FFFE;

   vec_t vecs[8];
   int   base;

   initial begin
      vecs[0] = mk("digits_1234", "1234A",                   80'hFFFF_FFFF_FFFF_FFFF_1234);
      vecs[1] = mk("cancel_78",   "78B",                     80'hFFFF_FFFF_FFFF_FFFF_FFFB);
      vecs[2] = mk("entry_9",     "9A",                      80'hFFFF_FFFF_FFFF_FFFF_FFF9);
      vecs[3] = mk("overflow_22", "0123456789012345678912A", 80'h0123_4567_8901_2345_6789);
      vecs[4] = mk("enter_idle",  "A",                       VAZIO);
      vecs[5] = mk("cancel_idle", "B",                       80'hFFFF_FFFF_FFFF_FFFF_FFFB);
      vecs[6] = mk("ignored_cf",  "3CDEF5A",                 80'hFFFF_FFFF_FFFF_FFFF_FF35);
      vecs[7] = mk("digit_zero",  "0A",                      80'hFFFF_FFFF_FFFF_FFFF_FFF0);

      rst = 1'b1; teclado_en = 1'b1; key_valid = 1'b0; key_code = 4'h0;
      repeat (3) @(negedge clk);
      check("reset_valid", 80'(digitos_valid), 80'd0);
      check("reset_value", digitos_value, VAZIO);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         base = pulses;
         for (int k = 0; k < vecs[i].n; k++) press(vecs[i].keys[k]);
         repeat (3) @(negedge clk);
         check({vecs[i].name, "_pulses"}, 80'(pulses - base), 80'd1);
         check({vecs[i].name, "_packet"}, pac_seen, vecs[i].exp);
         check({vecs[i].name, "_held"}, digitos_value, vecs[i].exp);
      end

      // Timeout: key 5, then silence; pulse appears exactly T+1 negedges later.
      base = pulses;
      press(4'h5);
      repeat (T - 1) @(negedge clk);
      check("timeout_not_early", 80'(digitos_valid), 80'd0);
      @(negedge clk);
      check("timeout_pulse", 80'(digitos_valid), 80'd1);
      check("timeout_value", digitos_value, EXPIRA);
      repeat (2 * T) @(negedge clk);
      check("timeout_single", 80'(pulses - base), 80'd1);

      // Key lands in the exact expiry cycle: no timeout, timer restarts.
      base = pulses;
      press(4'h5);
      repeat (T - 1) @(negedge clk);
      press(4'h6);
      check("expiry_key_wins", 80'(digitos_valid), 80'd0);
      repeat (T - 1) @(negedge clk);
      check("expiry_restart_quiet", 80'(digitos_valid), 80'd0);
      @(negedge clk);
      check("expiry_restart_pulse", 80'(digitos_valid), 80'd1);
      check("expiry_restart_value", digitos_value, EXPIRA);
      repeat (3) @(negedge clk);
      check("expiry_pulses", 80'(pulses - base), 80'd1);

      // Enable drop mid-entry discards silently; a key while disabled is ignored.
      base = pulses;
      press(4'h1);
      press(4'h2);
      teclado_en = 1'b0;
      press(4'h3);
      teclado_en = 1'b1;
      repeat (2) @(negedge clk);
      check("en_drop_silent", 80'(pulses - base), 80'd0);
      press(KEY_ENTER);
      repeat (2) @(negedge clk);
      check("en_drop_pulses", 80'(pulses - base), 80'd1);
      check("en_drop_value", pac_seen, VAZIO);

      // Keys during EMITIR are ignored.
      base = pulses;
      press(4'h4);
      press(KEY_ENTER);
      press(4'h7);
      press(KEY_ENTER);
      repeat (2) @(negedge clk);
      check("emitir_pulses", 80'(pulses - base), 80'd2);
      check("emitir_ignore_value", digitos_value, VAZIO);

      // Reset during EMITIR kills the strobe immediately.
      press(4'h3);
      press(KEY_ENTER);
      check("emitir_pre_rst", 80'(digitos_valid), 80'd1);
      rst = 1'b1;
      #1;
      check("rst_async_valid", 80'(digitos_valid), 80'd0);
      check("rst_async_value", digitos_value, VAZIO);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset mid-entry: nothing emitted, next entry starts clean.
      base = pulses;
      press(4'h1);
      press(4'h2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (T + 5) @(negedge clk);
      check("rst_mid_silent", 80'(pulses - base), 80'd0);
      press(4'h6);
      press(KEY_ENTER);
      repeat (2) @(negedge clk);
      check("rst_mid_next", pac_seen, 80'hFFFF_FFFF_FFFF_FFFF_FFF6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/coletor_digitos.md
COLETOR_DIGITOS -- requirements
Module: coletor_digitos

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 5000: idle cycles after the last accepted key before an entry expires.
REQ-002 The block SHALL have parameter MAX_DIGITS, default 20: digit capacity of one entry; it SHALL equal the senhaPac_t digit count.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset: clk, input, 1 bit, rising-edge clock; rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port teclado_en, input, 1 bit: keypad enable from the lock control unit.
REQ-005 The block SHALL have port key_code, input, 4 bits: key pressed; 0x0-0x9 digit, 0xA enter, 0xB cancel, 0xC-0xF ignored.
REQ-006 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-007 The block SHALL have port digitos_value, output, senhaPac_t: assembled entry packet.
REQ-008 The block SHALL have port digitos_valid, output, 1 bit: one-cycle strobe qualifying digitos_value.

Function
REQ-009 The block SHALL implement the FSM IDLE, COLETANDO, EMITIR.
REQ-010 Packet format SHALL be: digits[0] = newest digit, older digits in ascending index, unused slots 0xF.
REQ-011 In IDLE, a digit key SHALL clear the buffer, store the digit in digits[0], set count=1 and go to COLETANDO.
REQ-012 In COLETANDO, a digit key with count<MAX_DIGITS SHALL shift the buffer up one slot, insert the digit at digits[0] and increment count.
REQ-013 A digit key at count=MAX_DIGITS SHALL be ignored and SHALL NOT restart the timer.
REQ-014 Enter (0xA) in COLETANDO SHALL go to EMITIR with the buffer unchanged.
REQ-015 Enter in IDLE SHALL emit a packet with all slots 0xF (empty entry).
REQ-016 Cancel (0xB) in any state other than EMITIR SHALL emit a packet with digits[0]=0xB and all other slots 0xF, and SHALL discard the buffer.
REQ-017 Every accepted key in COLETANDO SHALL reset the inactivity counter to 0; otherwise the counter SHALL increment by 1 per cycle.
REQ-018 Inactivity counter reaching TIMEOUT_CYCLES-1 with no key in that cycle SHALL emit digits[0]=0xE, other slots 0xF, and SHALL discard the buffer.
REQ-019 A key arriving in the same cycle as timeout expiry SHALL take priority, and no timeout packet SHALL be emitted.
REQ-020 digitos_valid SHALL be registered and assert exactly one cycle, in the cycle after the terminating key or timeout, with digitos_value stable in that cycle.
REQ-021 EMITIR SHALL last one cycle and then go to IDLE; keys presented during EMITIR SHALL be ignored.
REQ-022 digitos_value SHALL hold the last packet until the next emission.
REQ-023 teclado_en low SHALL force IDLE, clear count and timer, reset the buffer to all 0xF, ignore keys and emit nothing.
REQ-024 teclado_en falling mid-entry SHALL discard the entry silently.
REQ-025 key_valid high with key_code 0xC-0xF SHALL have no effect, including on the timer.
REQ-026 The digit count SHALL be 5 bits wide; the inactivity counter SHALL be 32 bits wide and SHALL NOT wrap while in IDLE (it SHALL be held at 0).

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, count=0, timer=0, digitos_valid=0 and digitos_value all slots 0xF.
REQ-028 Reset asserted mid-entry or during EMITIR SHALL drop the entry and any pending strobe.

Structure
REQ-029 senhaPac_t and the key-code constants (KEY_ENTER=0xA, KEY_CANCEL=0xB, CODE_EXPIRED=0xE, CODE_EMPTY=0xF) SHALL live in the shared fechadura package, together with the control unit's types.
REQ-030 One sub-module, temporizador_inatividade, SHALL provide the clear and enable inputs and the expired output; all other logic SHALL be in a single module.

Verification
REQ-031 Keys 1,2,3,4 then 0xA -> one digitos_valid pulse, digits[0]=4, [1]=3, [2]=2, [3]=1, [4..19]=0xF.
REQ-032 Key 5, then no key for TIMEOUT_CYCLES cycles -> one pulse with digits[0]=0xE, rest 0xF; no further pulse.
REQ-033 Keys 7,8 then 0xB -> pulse with digits[0]=0xB; next entry 9, 0xA -> digits[0]=9, [1..19]=0xF.
REQ-034 22 digit keys 0..9,0..9,1,2 then 0xA -> the last two are dropped and digits[0]=9 ... digits[19]=0.
REQ-035 Key at the exact expiry cycle -> no 0xE packet and the timer restarts.
REQ-036 Keys 1,2 then teclado_en=0 for 1 cycle, then 0xA -> no pulse until 0xA, which emits the all-0xF packet; rst asserted mid-entry -> digitos_valid stays 0.
